// File: rtl/rf_scrub_ctrl_pkg.sv
// Shared types for the GPR scrubber: FSM state encoding, RF address type and last GPR index.
package rf_scrub_ctrl_pkg;
  localparam int RF_ADDR_W = 5;
  typedef logic [RF_ADDR_W-1:0] rf_add_t;
  localparam rf_add_t LAST_ADD = rf_add_t'(31);
  typedef enum logic [2:0] {IDLE, WAIT, READ, CMP, WRITE} rfscrub_state;
endpackage

// File: rtl/rf_par_sel.sv
// Picks the trustworthy copy of a duplicated, even-parity RF entry.
// sel=1 selects copy 1; fix asks for a rewrite; err flags an unresolvable mismatch.
module rf_par_sel #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] val0,
  input  logic            par0,
  input  logic [XLEN-1:0] val1,
  input  logic            par1,
  output logic            sel,
  output logic            fix,
  output logic            err
);
  logic ok0, ok1, same;

  always_comb begin
    ok0  = ((^val0) == par0);
    ok1  = ((^val1) == par1);
    same = (val0 == val1) && (par0 == par1);
    sel  = ok1 & ~ok0;
    fix  = ~same & (ok0 ^ ok1);
    err  = ~same & ~(ok0 ^ ok1);
  end
endmodule

// File: rtl/rf_scrub_ctrl.sv
// Background scrubber and repair sequencer for the duplicated GPR file (x1..x31).
// Define RFSCRUB_STATS_EN to add saturating fix/error counters and a pass-complete pulse.
module rf_scrub_ctrl
  import rf_scrub_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int XLEN       = 32,
  parameter int FIRST_ADD  = 1,
  parameter int RD_TIMEOUT = 64
) (
  input  logic              s_clk_i,
  input  logic              s_reset_i,
  input  logic              s_enable_i,
  input  logic [15:0]       s_interval_i,
  input  logic              s_rd_free_i,
  output logic              s_rd_req_o,
  output logic [ADDR_W-1:0] s_rd_add_o,
  input  logic [XLEN-1:0]   s_rd0_val_i,
  input  logic              s_rd0_par_i,
  input  logic [XLEN-1:0]   s_rd1_val_i,
  input  logic              s_rd1_par_i,
  input  logic              s_wb_we_i,
  input  logic [ADDR_W-1:0] s_wb_add_i,
  output logic              s_wr_we_o,
  output logic [ADDR_W-1:0] s_wr_add_o,
  output logic [XLEN-1:0]   s_wr_val_o,
  output logic              s_wr_par_o,
  output logic              s_fix_o,
  output logic              s_err_o,
  output logic              s_starve_o,
`ifdef RFSCRUB_STATS_EN
  output logic [15:0]       s_fix_cnt_o,
  output logic [15:0]       s_err_cnt_o,
  output logic              s_pass_o,
`endif
  output logic              s_busy_o
);
  localparam int WCNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(FIRST_ADD);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(LAST_ADD);

  rfscrub_state      state;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [15:0]       icnt;
  logic [WCNT_W-1:0] wcnt;
  logic [XLEN-1:0]   v0_q, v1_q, wr_val_q;
  logic              p0_q, p1_q, wr_par_q, starve_q;
  logic              sel, sel_fix, sel_err;
  logic              hz, wr_go, err_go, adv;

  rf_par_sel #(.XLEN(XLEN)) u_sel (
    .val0(v0_q), .par0(p0_q), .val1(v1_q), .par1(p1_q),
    .sel(sel), .fix(sel_fix), .err(sel_err)
  );

  // A writeback to the entry under inspection makes the captured data stale.
  always_comb begin
    hz      = s_wb_we_i && (s_wb_add_i == ptr);
    wr_go   = (state == WRITE) && !s_wb_we_i;
    err_go  = (state == CMP) && !hz && sel_err;
    adv     = ((state == CMP) && !hz && !sel_fix) || wr_go;
    ptr_nxt = (ptr == LAST) ? FIRST : ptr + ADDR_W'(1);
  end

  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      state    <= IDLE;
      ptr      <= FIRST;
      icnt     <= '0;
      wcnt     <= '0;
      starve_q <= 1'b0;
      v0_q     <= '0;
      v1_q     <= '0;
      p0_q     <= 1'b0;
      p1_q     <= 1'b0;
      wr_val_q <= '0;
      wr_par_q <= 1'b0;
    end else begin
      if (adv) ptr <= ptr_nxt;
      case (state)
        IDLE:
          if (s_enable_i) begin
            icnt  <= s_interval_i;
            state <= WAIT;
          end
        WAIT:
          if (!s_enable_i) state <= IDLE;
          else if (icnt == '0) begin
            state <= READ;
            wcnt  <= '0;
          end else icnt <= icnt - 16'd1;
        READ:
          if (s_rd_free_i) begin
            v0_q     <= s_rd0_val_i;
            p0_q     <= s_rd0_par_i;
            v1_q     <= s_rd1_val_i;
            p1_q     <= s_rd1_par_i;
            starve_q <= 1'b0;
            if (hz) begin
              state <= WAIT;
              icnt  <= s_interval_i;
            end else state <= CMP;
          end else begin
            if (wcnt != WCNT_W'(RD_TIMEOUT)) wcnt <= wcnt + WCNT_W'(1);
            if (wcnt == WCNT_W'(RD_TIMEOUT - 1)) starve_q <= 1'b1;
          end
        CMP:
          if (hz) begin
            state <= WAIT;
            icnt  <= s_interval_i;
          end else if (sel_fix) begin
            state    <= WRITE;
            wr_val_q <= sel ? v1_q : v0_q;
            wr_par_q <= sel ? p1_q : p0_q;
          end else begin
            state <= s_enable_i ? WAIT : IDLE;
            icnt  <= s_interval_i;
          end
        WRITE:
          if (hz) begin
            state <= WAIT;
            icnt  <= s_interval_i;
          end else if (!s_wb_we_i) begin
            state <= s_enable_i ? WAIT : IDLE;
            icnt  <= s_interval_i;
          end
        default: state <= IDLE;
      endcase
    end
  end

  assign s_rd_req_o = (state == READ);
  assign s_rd_add_o = (state == READ) ? ptr : '0;
  assign s_wr_we_o  = wr_go;
  assign s_fix_o    = wr_go;
  assign s_wr_add_o = (state == WRITE) ? ptr : '0;
  assign s_wr_val_o = (state == WRITE) ? wr_val_q : '0;
  assign s_wr_par_o = (state == WRITE) ? wr_par_q : 1'b0;
  assign s_err_o    = err_go;
  assign s_starve_o = starve_q;
  assign s_busy_o   = (state == READ) || (state == CMP) || (state == WRITE);

`ifdef RFSCRUB_STATS_EN
  always_ff @(posedge s_clk_i) begin
    if (s_reset_i) begin
      s_fix_cnt_o <= '0;
      s_err_cnt_o <= '0;
      s_pass_o    <= 1'b0;
    end else begin
      if (wr_go && s_fix_cnt_o != 16'hFFFF) s_fix_cnt_o <= s_fix_cnt_o + 16'd1;
      if (err_go && s_err_cnt_o != 16'hFFFF) s_err_cnt_o <= s_err_cnt_o + 16'd1;
      s_pass_o <= adv && (ptr == LAST);
    end
  end
`endif
endmodule

// File: doc/rf_scrub_ctrl.md
Name: rf_scrub_ctrl

Overview:
- Background scrubber and repair sequencer for the duplicated 32x32 GPR file (copy 0 and copy 1, each entry with one even-parity bit).
- Walks x1..x31 in idle read-port slots and compares both copies.
- On mismatch, picks the copy whose parity is consistent and rewrites both copies with it. It uses the RF write port only in cycles where writeback does not.
- Sits beside the register-file controller; the pipeline always has priority on both ports.

Parameters:
- ADDR_W, 5, GPR address width
- XLEN, 32, data width
- FIRST_ADD, 1, first scrubbed address; x0 is never scrubbed
- RD_TIMEOUT, 64, cycles to wait for a read slot before raising s_starve_o

Ports:
- s_clk_i  in  1  clock
- s_reset_i  in  1  synchronous reset, active-high
- s_enable_i  in  1  scrub enable
- s_interval_i  in  16  idle cycles between consecutive scrub reads; 0 means back-to-back
- s_rd_free_i  in  1  pipeline does not use the scrub read port this cycle
- s_rd_req_o  out  1  scrub read request
- s_rd_add_o  out  ADDR_W  scrub read address, driven to both copies
- s_rd0_val_i  in  XLEN  copy 0 data, combinational from s_rd_add_o
- s_rd0_par_i  in  1  copy 0 stored parity
- s_rd1_val_i  in  XLEN  copy 1 data
- s_rd1_par_i  in  1  copy 1 stored parity
- s_wb_we_i  in  1  writeback writes the RF this cycle
- s_wb_add_i  in  ADDR_W  writeback address
- s_wr_we_o  out  1  repair write enable, for both copies
- s_wr_add_o  out  ADDR_W  repair address
- s_wr_val_o  out  XLEN  repair data
- s_wr_par_o  out  1  repair parity
- s_fix_o  out  1  one-cycle pulse: repair write performed
- s_err_o  out  1  one-cycle pulse: uncorrectable mismatch
- s_starve_o  out  1  level: read slot not granted within RD_TIMEOUT
- s_busy_o  out  1  FSM not in IDLE/WAIT

Behaviour:
- Reset: all outputs 0, state IDLE, address pointer = FIRST_ADD, interval counter = 0.
- Read transfer: occurs in a cycle where s_rd_req_o && s_rd_free_i.
- Write condition: s_wr_we_o is asserted only when s_wb_we_i == 0, so writeback always wins. s_wr_we_o never combinationally depends on s_rd_free_i.
- FSM states:
  - IDLE: if s_enable_i, load counter with s_interval_i and go to WAIT.
  - WAIT: decrement counter; at 0 go to READ. If s_enable_i drops, go to IDLE.
  - READ: s_rd_req_o = 1, s_rd_add_o = pointer. On a transfer, register both values and parities and go to CMP. Count wait cycles; when the count reaches RD_TIMEOUT, set s_starve_o (stays set until a transfer occurs) and keep waiting.
  - CMP, one cycle:
    - Compute parity of each copy: pN_ok = (^valN == parN).
    - vals equal and parities equal → no fix.
    - Exactly one copy has pN_ok → select that copy and go to WRITE.
    - Equal vals with differing parity → the copy with pN_ok is selected; same outcome.
    - Otherwise (both ok but different, or both bad) → pulse s_err_o, no write.
    - After no fix or error: advance pointer and go to WAIT (or IDLE if disabled).
  - WRITE: drive address/value/parity; assert s_wr_we_o when s_wb_we_i == 0, pulse s_fix_o in the same cycle, advance pointer, go to WAIT/IDLE.
- Writeback hazard: if s_wb_we_i && s_wb_add_i == pointer in any cycle from the transfer through WRITE (before the repair write), abort. No write, no fix/err pulse, pointer is not advanced, return to WAIT so the entry is rescrubbed.
- Pointer wrap: 31 → FIRST_ADD.
- Disable: s_enable_i = 0 mid-operation only stops the walk after the current entry completes (CMP/WRITE finish).
- Reset mid-operation: immediate return to reset state; an in-flight repair is dropped.
- Latency: transfer → CMP is 1 cycle; earliest repair write is 2 cycles after transfer.

Optional Feature:
- Macro: RFSCRUB_STATS_EN.
- When defined, adds the following, all reset to 0:
  - s_fix_cnt_o (16-bit, saturating count of s_fix_o)
  - s_err_cnt_o (16-bit, saturating count of s_err_o)
  - s_pass_o (pulses when the pointer wraps 31 → FIRST_ADD)
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared package: state enum rfscrub_state {IDLE, WAIT, READ, CMP, WRITE}, the RF address type, and the constant for the last GPR index (31).
- One natural sub-module: rf_par_sel, combinational. It takes both values and parities and returns select, fix and error.

Test Plan:
- No error, interval = 0, s_rd_free_i = 1:
  - Addresses 1..31 are read in order, then wrap to 1.
  - No s_wr_we_o, s_fix_o or s_err_o.
  - One READ per entry, 2-cycle CMP/WAIT gap.
- Copy1[5] = 0x0000_0001 with par 0 (bad), copy0[5] = 0 with par 0:
  - Write to add 5 with val 0x0, par 0.
  - s_fix_o pulses 2 cycles after the transfer.
- Both copies of x7 differ and both parities are valid:
  - s_err_o pulses once, no write, pointer moves to 8.
- Repair pending for x9 while s_wb_we_i = 1 to add 3 for 4 cycles:
  - s_wr_we_o is held off and is asserted the first cycle s_wb_we_i = 0.
  - Same case with s_wb_add_i = 9: abort, no write, x9 rescrubbed.
- s_rd_free_i held 0 for 70 cycles:
  - s_starve_o rises at cycle 64 and clears after the first transfer.
- Reset asserted during WRITE:
  - Next cycle all outputs are 0 and the pointer is 1.
  - With RFSCRUB_STATS_EN, the counters read 0.
